// File: rtl/data_mem_responder_pkg.sv
// Shared types and widths for the data memory responder slice.
package mem_pkg;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WORD_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   // Request captured in the acceptance cycle
   typedef struct packed {
      logic              rd;
      logic              wr;
      logic [WORD_W-1:0] adr;
      logic [WORD_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage to data memory handshake bundle.
// memErr exists only when DATA_MEM_ADDR_CHECK_EN is defined.
interface data_mem_responder_if;
   import mem_pkg::*;

   logic              memRead;
   logic              memWrite;
   logic [WORD_W-1:0] adr;
   logic [WORD_W-1:0] writeData;
   logic [WORD_W-1:0] readData;
   logic              memReady;
   logic              memStall;
`ifdef DATA_MEM_ADDR_CHECK_EN
   logic              memErr;

   modport master (
      output memRead, memWrite, adr, writeData,
      input  readData, memReady, memStall, memErr
   );

   modport slave (
      input  memRead, memWrite, adr, writeData,
      output readData, memReady, memStall, memErr
   );
`else
   modport master (
      output memRead, memWrite, adr, writeData,
      input  readData, memReady, memStall
   );

   modport slave (
      input  memRead, memWrite, adr, writeData,
      output readData, memReady, memStall
   );
`endif

endinterface

// File: rtl/data_mem_responder_mem_word_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read, never reset.
module mem_word_array
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   // Word write on the rising edge
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder for a pipeline MEM stage.
// Optional DATA_MEM_ADDR_CHECK_EN adds memErr and blocks misaligned or
// out-of-range accesses; otherwise adr[1:0] is ignored and the index wraps.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DEPTH   = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   data_mem_responder_if.slave   bus
);

   localparam int unsigned AW = $clog2(DEPTH);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;

   logic              req_c;
   logic              ready_c;
   logic              we_c;
   logic              err_c;
   logic [AW-1:0]     idx_c;
   logic [WORD_W-1:0] arr_rdata;
   logic [WORD_W-1:0] ret_c;

   assign req_c = bus.memRead | bus.memWrite;
   assign idx_c = req_q.adr[AW+1:2];

`ifdef DATA_MEM_ADDR_CHECK_EN
   // Latched address must be word aligned and inside the array
   assign err_c = (req_q.adr[1:0] != 2'b00) ||
                  (64'(req_q.adr) >= (64'(DEPTH) * 64'd4));
`else
   logic unused_adr_bits;
   assign err_c = 1'b0;
   assign unused_adr_bits = ^{req_q.adr[WORD_W-1:AW+2], req_q.adr[1:0]};
`endif

   // Returned word: blocked access reads zero, store-and-load echoes the store
   assign ret_c = err_c    ? '0 :
                  req_q.wr ? req_q.wdata : arr_rdata;

   // Request FSM: accept in IDLE, count down in WAIT, abort on dropped request
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      ready_c = 1'b0;
      we_c    = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_c) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(LATENCY - 1);
               req_d   = '{rd:    bus.memRead,
                           wr:    bus.memWrite,
                           adr:   bus.adr,
                           wdata: bus.writeData};
            end
         end
         WAIT: begin
            if (!req_c) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = IDLE;
               if (!rst) begin
                  ready_c = 1'b1;
                  we_c    = req_q.wr & ~err_c;
                  if (req_q.rd) begin
                     rdata_d = ret_c;
                  end
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter, latched request and held load data
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
      end
   end

   mem_word_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (we_c),
      .waddr_i (idx_c),
      .wdata_i (req_q.wdata),
      .raddr_i (idx_c),
      .rdata_o (arr_rdata)
   );

   assign bus.memReady = ready_c;
   assign bus.memStall = req_c & ~ready_c;
   assign bus.readData = rdata_d;
`ifdef DATA_MEM_ADDR_CHECK_EN
   assign bus.memErr   = ready_c & err_c;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (LATENCY=2, DEPTH=256).
`timescale 1ns/1ps
module tb_data_mem_responder;
   import mem_pkg::*;

   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned NW    = 16;

   typedef struct {
      int unsigned cyc;
      logic        ld;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   bit          mon_en = 1'b0;

   exp_t        sbq[$];
   logic [31:0] mem_m [DEPTH];
   logic [31:0] last_rd = '0;

   data_mem_responder_if bus ();

   data_mem_responder #(
      .LATENCY (LAT),
      .DEPTH   (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic model_err(input logic [31:0] a);
`ifdef DATA_MEM_ADDR_CHECK_EN
      return (a[1:0] != 2'b00) || (64'(a) >= 64'(DEPTH) * 64'd4);
`else
      return 1'b0;
`endif
   endfunction

   // Monitor: compare every cycle against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      logic exp_ready;
      if (rst) begin
         sbq.delete();
         last_rd = '0;
      end else if (mon_en) begin
         while (sbq.size() != 0 && sbq[0].cyc < cyc) void'(sbq.pop_front());
         exp_ready = (sbq.size() != 0) && (sbq[0].cyc == cyc);
         check("memReady", 32'(bus.memReady), 32'(exp_ready));
         check("memStall", 32'(bus.memStall),
               32'((bus.memRead | bus.memWrite) & ~exp_ready));
         if (exp_ready) begin
            e = sbq.pop_front();
            if (e.ld) last_rd = e.rd;
            check("readData", bus.readData, last_rd);
`ifdef DATA_MEM_ADDR_CHECK_EN
            check("memErr", 32'(bus.memErr), 32'(e.err));
`endif
         end else begin
            check("readData_hold", bus.readData, last_rd);
`ifdef DATA_MEM_ADDR_CHECK_EN
            check("memErr_idle", 32'(bus.memErr), 32'd0);
`endif
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
      bus.memRead   = rd;
      bus.memWrite  = wr;
      bus.adr       = a;
      bus.writeData = wd;
   endtask

   // Issue one request in the next cycle and hold it until memReady
   task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit scramble);
      exp_t        e;
      int unsigned w;
      step();
      drive(rd, wr, a, wd);
      w     = int'((a >> 2) % DEPTH);
      e.cyc = cyc + LAT;
      e.ld  = rd;
      e.err = model_err(a);
      if (e.err)   e.rd = '0;
      else if (wr) e.rd = wd;
      else         e.rd = mem_m[w];
      if (wr && !e.err) mem_m[w] = wd;
      sbq.push_back(e);
      for (int i = 0; i < int'(LAT) + 4; i++) begin
         step();
         if (bus.memReady) return;
         if (scramble) begin
            bus.adr       = $urandom;
            bus.writeData = $urandom;
         end
      end
      checks++;
      errors++;
      $display("FAIL completion_timeout adr=%h: got no memReady expected one", a);
      drive(1'b0, 1'b0, '0, '0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         drive(1'b0, 1'b0, '0, '0);
      end
   endtask

   initial begin
      logic [31:0] saved;
      logic [31:0] a;
      int          op;

      drive(1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      repeat (3) step();
      rst    = 1'b0;
      mon_en = 1'b1;
      step();
      check("reset_readData", bus.readData, 32'd0);
      check("reset_memReady", 32'(bus.memReady), 32'd0);

      // Known contents for every word the bench touches
      for (int i = 0; i < int'(NW); i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
      idle(1);

      // Store then load at 0x10, with address/data changes during the wait
      issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
      idle(3);
      check("load_0x10_held", bus.readData, 32'hDEADBEEF);

      // Load dropped in the first wait cycle, then immediately accepted request
      saved = last_rd;
      step();
      drive(1'b1, 1'b0, 32'h20, '0);
      step();
      drive(1'b0, 1'b0, '0, '0);
      issue(1'b1, 1'b0, 32'h8, '0, 1'b0);
      idle(2);
      check("abort_then_load", bus.readData, mem_m[2]);

      // Reset during a store to 0x20: no write, readData cleared
      saved = mem_m[8];
      step();
      drive(1'b0, 1'b1, 32'h20, 32'hBADC0FFE);
      step();
      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0);
      step();
      rst = 1'b0;
      step();
      check("rst_clears_readData", bus.readData, 32'd0);
      issue(1'b1, 1'b0, 32'h20, '0, 1'b0);
      idle(1);
      check("rst_store_suppressed", bus.readData, saved);

      // Read and write together behave as a store that echoes writeData
      issue(1'b1, 1'b1, 32'h30, 32'h12345678, 1'b0);
      issue(1'b1, 1'b0, 32'h0, '0, 1'b0);
      issue(1'b1, 1'b0, 32'h30, '0, 1'b0);
      idle(1);
      check("both_high_word", bus.readData, 32'h12345678);

      // Misaligned and out-of-range addresses
      issue(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0);
      issue(1'b0, 1'b1, 32'h13, 32'h5A5A5A5A, 1'b0);
      issue(1'b1, 1'b0, 32'h10, '0, 1'b0);
      issue(1'b0, 1'b1, 32'(DEPTH * 4), 32'hC0DEC0DE, 1'b0);
      issue(1'b1, 1'b0, 32'h0, '0, 1'b0);
      issue(1'b1, 1'b0, 32'(DEPTH * 4 + 8), '0, 1'b0);
      idle(2);

      // Randomized traffic with aliasing, low-bit noise and gaps
      for (int n = 0; n < 300; n++) begin
         a = 32'($urandom_range(0, NW - 1) * 4);
         if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) a = a + 32'(DEPTH * 4 * $urandom_range(1, 3));
         op = int'($urandom_range(0, 2));
         case (op)
            0:       issue(1'b1, 1'b0, a, $urandom, 1'b1);
            1:       issue(1'b0, 1'b1, a, $urandom, 1'b1);
            default: issue(1'b1, 1'b1, a, $urandom, 1'b1);
         endcase
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(LAT + 3);

      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be: LATENCY, 2, cycles from request acceptance to memReady (legal 1..15); DEPTH, 256, number of 32-bit words (power of two).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Port memRead  input  1  load request from MEM stage; held until memReady.
REQ-005 Port memWrite  input  1  store request from MEM stage; held until memReady.
REQ-006 Port adr  input  32  byte address; word index = adr[log2(DEPTH)+1:2].
REQ-007 Port writeData  input  32  store data.
REQ-008 Port readData  output  32  load data; valid in the memReady cycle.
REQ-009 Port memReady  output  1  one-cycle completion pulse.
REQ-010 Port memStall  output  1  pipeline hold = (memRead | memWrite) & ~memReady, combinational.

Function
REQ-011 FSM SHALL have states IDLE and WAIT.
REQ-012 IDLE with memRead|memWrite high SHALL accept the request (cycle 0), latch adr, writeData and op, load counter with LATENCY-1, and go to WAIT.
REQ-013 WAIT SHALL decrement counter each cycle; when counter==0, memReady SHALL be high that cycle and state SHALL return to IDLE next cycle.
REQ-014 memReady SHALL therefore assert exactly LATENCY cycles after the acceptance cycle, for exactly one cycle.
REQ-015 Load: readData SHALL show the addressed word in the memReady cycle and hold it until the next load completes.
REQ-016 Store: the word SHALL be written on the clock edge ending the memReady cycle; readData unchanged.
REQ-017 memRead and memWrite both high SHALL be treated as a store; readData SHALL return writeData in the memReady cycle.
REQ-018 Request dropped (memRead and memWrite both low) while in WAIT SHALL abort: return to IDLE next cycle, no write, no memReady.
REQ-019 Address/data changes during WAIT SHALL be ignored (latched values used).
REQ-020 Request still high in the IDLE cycle after memReady SHALL be accepted as a new request.
REQ-021 Without the configuration macro, adr[1:0] SHALL be ignored and index SHALL wrap modulo DEPTH.

Reset
REQ-022 rst SHALL force state IDLE, counter 0, memReady 0, readData 32'd0, latched request cleared; it overrides an in-flight access, which SHALL NOT write.
REQ-023 Storage array contents SHALL NOT be cleared by rst.

Configuration
REQ-024 Macro DATA_MEM_ADDR_CHECK_EN SHALL, when defined, add output memErr (1 bit, reset 0) asserted only in the memReady cycle when the latched adr[1:0]!=0 or adr>=DEPTH*4; such a store SHALL be suppressed and such a load SHALL return 32'd0.
REQ-025 Without DATA_MEM_ADDR_CHECK_EN the memErr port SHALL not exist and REQ-021 applies.

Structure
REQ-026 Shared package mem_pkg SHALL hold the state enum (IDLE, WAIT), the counter width constant (4), and the word width constant (32).
REQ-027 Storage SHALL be a sub-module mem_word_array (synchronous write, combinational read, DEPTH x 32).

Verification
REQ-028 LATENCY=2: memWrite, adr=0x10, writeData=0xDEADBEEF at cycle 0 -> memReady high cycle 2 only, memStall high cycles 0-1.
REQ-029 Then memRead adr=0x10 -> readData=0xDEADBEEF in its memReady cycle and held afterwards.
REQ-030 memRead dropped at cycle 1 of a LATENCY=3 load -> no memReady, FSM IDLE at cycle 2, readData unchanged.
REQ-031 rst at cycle 1 of a store to adr=0x20 -> no memReady, later load of 0x20 returns the prior contents.
REQ-032 memRead and memWrite both high, writeData=0x12345678 -> readData=0x12345678 in the memReady cycle and word updated.
REQ-033 DATA_MEM_ADDR_CHECK_EN defined: store adr=0x13 -> memErr with memReady, word 0x10 unchanged; undefined: adr=DEPTH*4 aliases to word 0.
